// File: rtl/display_7_if.sv
// display_7_if: nibble-in / segment-out link between datapath and digit driver
interface display_7_if;
    logic [3:0] palabra;
    logic [6:0] seg;
    modport master (output palabra, input seg);
    modport slave (input palabra, output seg);
endinterface

// File: rtl/display_7.sv
// display_7: registered hex-to-seven-segment decoder, seg = {g,f,e,d,c,b,a}
module display_7 #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic clk,
    input logic rst,
    display_7_if.slave bus
);
    logic [6:0] pat;
    localparam logic [6:0] OFF = ACTIVE_LOW ? 7'h7f : 7'h00;
    // active-high glyph lookup; unknown input falls to the blank pattern
    always_comb begin
        case (bus.palabra)
            4'h0: pat = 7'b0111111;
            4'h1: pat = 7'b0000110;
            4'h2: pat = 7'b1011011;
            4'h3: pat = 7'b1001111;
            4'h4: pat = 7'b1100110;
            4'h5: pat = 7'b1101101;
            4'h6: pat = 7'b1111101;
            4'h7: pat = 7'b0000111;
            4'h8: pat = 7'b1111111;
            4'h9: pat = 7'b1101111;
            4'ha: pat = 7'b1110111;
            4'hb: pat = 7'b1111100;
            4'hc: pat = 7'b0111001;
            4'hd: pat = 7'b1011110;
            4'he: pat = 7'b1111001;
            4'hf: pat = 7'b1110001;
            default: pat = 7'b0000000;
        endcase
    end
    // register the pin drive, applying board polarity; reset blanks the digit
    always_ff @(posedge clk)
        bus.seg <= rst ? OFF : (ACTIVE_LOW ? ~pat : pat);
endmodule

// File: tb/tb_display_7.sv
// tb_display_7: directed checks of the registered seven-segment decoder
module tb_display_7;
    logic clk;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    display_7_if lo ();
    display_7_if hi ();
    display_7 #(.ACTIVE_LOW(1'b1)) dut_lo (.clk(clk), .rst(rst), .bus(lo.slave));
    display_7 #(.ACTIVE_LOW(1'b0)) dut_hi (.clk(clk), .rst(rst), .bus(hi.slave));
    logic [6:0] tbl [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        lo.palabra = 4'h8;
        hi.palabra = 4'h8;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++;
            if (lo.seg !== 7'b1111111) begin
                n_fail++;
                $display("FAIL reset_lo cycle %0d: got %b expected %b", i, lo.seg, 7'b1111111);
            end
            n_chk++;
            if (hi.seg !== 7'b0000000) begin
                n_fail++;
                $display("FAIL reset_hi cycle %0d: got %b expected %b", i, hi.seg, 7'b0000000);
            end
        end
    endtask
    task automatic test_sweep();
        rst = 1'b0;
        for (int v = 0; v < 16; v++) begin
            lo.palabra = 4'(v);
            step();
            n_chk++;
            if (lo.seg !== ~tbl[v]) begin
                n_fail++;
                $display("FAIL sweep digit %0h: got %b expected %b", v, lo.seg, ~tbl[v]);
            end
        end
    endtask
    task automatic test_latency();
        rst = 1'b0;
        lo.palabra = 4'h3;
        step();
        lo.palabra = 4'ha;
        #3;
        n_chk++;
        if (lo.seg !== 7'b0110000) begin
            n_fail++;
            $display("FAIL latency_hold: got %b expected %b", lo.seg, 7'b0110000);
        end
        step();
        n_chk++;
        if (lo.seg !== 7'b0001000) begin
            n_fail++;
            $display("FAIL latency_update: got %b expected %b", lo.seg, 7'b0001000);
        end
    endtask
    task automatic test_reset_mid();
        rst = 1'b0;
        for (int v = 0; v < 5; v++) begin
            lo.palabra = 4'(v);
            step();
        end
        lo.palabra = 4'h5;
        rst = 1'b1;
        step();
        n_chk++;
        if (lo.seg !== 7'b1111111) begin
            n_fail++;
            $display("FAIL reset_mid: got %b expected %b", lo.seg, 7'b1111111);
        end
        rst = 1'b0;
        step();
        n_chk++;
        if (lo.seg !== 7'b0010010) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", lo.seg, 7'b0010010);
        end
    endtask
    task automatic test_polarity();
        rst = 1'b0;
        hi.palabra = 4'h2;
        step();
        n_chk++;
        if (hi.seg !== 7'b1011011) begin
            n_fail++;
            $display("FAIL polarity_2: got %b expected %b", hi.seg, 7'b1011011);
        end
        hi.palabra = 4'hd;
        step();
        n_chk++;
        if (hi.seg !== 7'b1011110) begin
            n_fail++;
            $display("FAIL polarity_d: got %b expected %b", hi.seg, 7'b1011110);
        end
        rst = 1'b1;
        step();
        n_chk++;
        if (hi.seg !== 7'b0000000) begin
            n_fail++;
            $display("FAIL polarity_reset: got %b expected %b", hi.seg, 7'b0000000);
        end
        rst = 1'b0;
    endtask
    task automatic test_hold();
        rst = 1'b0;
        lo.palabra = 4'hc;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (lo.seg !== 7'b1000110) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got %b expected %b", i, lo.seg, 7'b1000110);
            end
        end
    endtask
    initial begin
        rst = 1'b1;
        lo.palabra = 4'h0;
        hi.palabra = 4'h0;
        test_reset();
        test_sweep();
        test_latency();
        test_reset_mid();
        test_polarity();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
